led_pulse_stretcher: RTL and testbench
======================================

# led_pulse_stretcher

Output-side conditioning block: turns single-cycle event strobes from the CPU/MMIO side into human-visible, minimum-duration levels on board LEDs or other slow outputs. It is the output counterpart of the input debouncer. Where the debouncer turns slow, noisy levels into clean logic, this block turns fast, clean strobes into slow, well-formed levels. It has one shared tick prescaler and one independent stretch state machine per channel.

## Interface
- WIDTH, 1: number of independent channels.
- SAMPLE_CNT_MAX, 25000: clock cycles per tick; must be ≥ 2.
- HOLD_CNT_MAX, 150: ticks an output stays high per event; must be ≥ 1.
- GAP_CNT_MAX, 50: ticks an output stays low after a hold; must be ≥ 1.
- RETRIGGER, 1: 1 = an event during hold restarts the hold; 0 = the event is queued behind the gap.
- TICK_CNT_WIDTH, $clog2(SAMPLE_CNT_MAX)+1: prescaler counter width.
- HOLD_CNT_WIDTH, $clog2(max(HOLD_CNT_MAX,GAP_CNT_MAX))+1: per-channel counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pulse  input  WIDTH  per-channel event strobe; any high cycle counts as one event.
- stretched  output  WIDTH  per-channel stretched level; registered.
- busy  output  WIDTH  per-channel: high whenever the channel state is not IDLE; registered.

## Operation
- **Prescaler:**
  - tick_cnt counts 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - tick is high for exactly one cycle when tick_cnt == SAMPLE_CNT_MAX-1.
  - The prescaler free-runs and is shared by all channels.
- **Per-channel state:** state ∈ {IDLE, HOLD, GAP}, counter cnt, and a 1-bit pending flag.
- **IDLE:**
  - pulse=1 → HOLD, cnt=0.
  - Otherwise stay in IDLE.
- **HOLD:**
  - stretched=1.
  - pulse=1 with RETRIGGER=1 → cnt=0, stay in HOLD. This takes priority over a same-cycle tick.
  - pulse=1 with RETRIGGER=0 → pending=1. The hold proceeds unaffected.
  - tick with cnt==HOLD_CNT_MAX-1 → GAP, cnt=0.
  - tick otherwise → cnt+1.
- **GAP:**
  - stretched=0.
  - pulse=1 → pending=1.
  - tick with cnt==GAP_CNT_MAX-1 → HOLD if pending (or same-cycle pulse), else IDLE; cnt=0.
  - tick otherwise → cnt+1.
- **Pending:**
  - pending is cleared on every entry into HOLD.
  - Multiple queued events collapse into one.
- **Outputs:**
  - stretched = (next_state==HOLD), registered.
  - busy = (next_state!=IDLE), registered.
  - Both are glitch-free flops, suitable for driving pins directly.
- **Independence:** channels share only the tick. An event on one channel never affects another.

## Timing
- **Reset:** when rst=1 at a clock edge:
  - tick_cnt=0, all states IDLE, all cnt=0, all pending=0.
  - stretched=0 and busy=0 on all bits.
  - pulse is ignored in a reset cycle.
  - Reset mid-HOLD or mid-GAP drops the output to 0 on the next edge and discards any pending event.
- **Latency:** pulse high in cycle n → stretched high in cycle n+1.
- **Hold duration:** from rising to falling edge of stretched, between (HOLD_CNT_MAX-1)·SAMPLE_CNT_MAX+1 and HOLD_CNT_MAX·SAMPLE_CNT_MAX cycles. The spread depends on prescaler phase; the duration is exact given the phase.
- **Gap duration:** between (GAP_CNT_MAX-1)·SAMPLE_CNT_MAX+1 and GAP_CNT_MAX·SAMPLE_CNT_MAX cycles low before a queued re-hold.
- **Back-to-back events:**
  - A pulse held high for many cycles counts as events on every cycle.
  - With RETRIGGER=1 the output therefore stays high for as long as pulse stays high, plus one hold.
- **Pulse on the final GAP tick:** goes straight to HOLD; there is no IDLE cycle.
- **Counter sizing:** counters never exceed their MAX-1, so there is no overflow at the parameter minimums.

## Test plan
Parameters for all scenarios: WIDTH=2, SAMPLE_CNT_MAX=4, HOLD_CNT_MAX=3, GAP_CNT_MAX=2, unless noted.

1. **Reset:**
   - Stimulus: rst=1 for 3 cycles with pulse=2'b11.
   - Required: stretched=busy=0 throughout; tick_cnt=0 on release; first tick 4 cycles after release.
2. **Single event:**
   - Stimulus: pulse[0] high for one cycle, aligned so tick_cnt==0 in that cycle.
   - Required: stretched[0] high from the next cycle for exactly 11 cycles ((3-1)·4+3), then low; busy[0] low after a further 8 cycles; stretched[1]=0 throughout.
3. **Retrigger:**
   - Stimulus: RETRIGGER=1; second pulse[0] 6 cycles after the first.
   - Required: stretched[0] stays continuously high; it falls 3 full ticks' worth of hold after the second event; no gap occurs between the two events.
4. **Queued event:**
   - Stimulus: RETRIGGER=0; three pulses[0] during one HOLD.
   - Required: exactly two high periods (the original plus one collapsed queued event), separated by a low gap of 5–8 cycles; then IDLE.
5. **Channel independence:**
   - Stimulus: pulse=2'b01, then pulse=2'b10 5 cycles later.
   - Required: both bits follow scenario 2 timing, offset by 5 cycles, with no cross-effect.
6. **Reset mid-operation:**
   - Stimulus: rst asserted 4 cycles into a HOLD that has a pending event (RETRIGGER=0).
   - Required: stretched[0]=0 on the next edge; no re-hold after rst is released.

Source files
------------

// File: rtl/led_pulse_stretcher.sv
// Output-side pulse stretcher: widens single-cycle event strobes into
// minimum-duration levels using one shared tick prescaler and one FSM per channel.
module led_pulse_stretcher #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int HOLD_CNT_MAX   = 150,
    parameter int GAP_CNT_MAX    = 50,
    parameter int RETRIGGER      = 1,
    parameter int TICK_CNT_WIDTH = $clog2(SAMPLE_CNT_MAX) + 1,
    parameter int HOLD_CNT_WIDTH = $clog2((HOLD_CNT_MAX > GAP_CNT_MAX) ? HOLD_CNT_MAX : GAP_CNT_MAX) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] stretched,
    output logic [WIDTH-1:0] busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST = TICK_CNT_WIDTH'(SAMPLE_CNT_MAX - 1);
    localparam logic [TICK_CNT_WIDTH-1:0] TICK_ONE  = TICK_CNT_WIDTH'(1);
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST = HOLD_CNT_WIDTH'(HOLD_CNT_MAX - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] GAP_LAST  = HOLD_CNT_WIDTH'(GAP_CNT_MAX - 1);
    localparam logic [HOLD_CNT_WIDTH-1:0] CNT_ONE   = HOLD_CNT_WIDTH'(1);
    localparam bit                        RETRIG_EN = (RETRIGGER != 0);

    logic [TICK_CNT_WIDTH-1:0] tick_cnt;
    logic                      tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

    // Outputs are registered from the next-state decision so pins see clean flops.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        state_t                    state;
        logic [HOLD_CNT_WIDTH-1:0] cnt;
        logic                      pending;
        logic                      stretched_q;
        logic                      busy_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state       <= IDLE;
                cnt         <= '0;
                pending     <= 1'b0;
                stretched_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pulse[i]) begin
                            state       <= HOLD;
                            cnt         <= '0;
                            pending     <= 1'b0;
                            stretched_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            stretched_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                    HOLD: begin
                        stretched_q <= 1'b1;
                        busy_q      <= 1'b1;
                        if (pulse[i] && RETRIG_EN) begin
                            cnt <= '0;
                        end else begin
                            if (pulse[i]) begin
                                pending <= 1'b1;
                            end
                            if (tick) begin
                                if (cnt == HOLD_LAST) begin
                                    state       <= GAP;
                                    cnt         <= '0;
                                    stretched_q <= 1'b0;
                                end else begin
                                    cnt <= cnt + CNT_ONE;
                                end
                            end
                        end
                    end
                    GAP: begin
                        stretched_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (tick && (cnt == GAP_LAST)) begin
                            cnt     <= '0;
                            pending <= 1'b0;
                            // A strobe on the final gap tick re-enters HOLD with no IDLE cycle.
                            if (pending || pulse[i]) begin
                                state       <= HOLD;
                                stretched_q <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            if (pulse[i]) begin
                                pending <= 1'b1;
                            end
                            if (tick) begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        cnt         <= '0;
                        pending     <= 1'b0;
                        stretched_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end

        assign stretched[i] = stretched_q;
        assign busy[i]      = busy_q;
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher: directed scenarios plus random strobes, compared
// every cycle against a countdown-based reference model for both retrigger modes.
module tb_led_pulse_stretcher;

    localparam int S       = 4;
    localparam int H       = 3;
    localparam int G       = 2;
    localparam int REC_MAX = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pulse;
    logic [1:0] str_rt, busy_rt;
    logic [1:0] str_q, busy_q;

    int n_checks = 0;
    int n_errors = 0;

    // k = 0: retrigger instance, k = 1: queueing instance
    int         m_tcnt = 0;
    int         hold_left [2][2];
    int         gap_left  [2][2];
    bit         queued    [2][2];
    logic [1:0] exp_s [2];
    logic [1:0] exp_b [2];

    logic [1:0] rec_s [2][REC_MAX];
    logic [1:0] rec_b [2][REC_MAX];
    int         rec_n = 0;

    always #5 clk = ~clk;

    led_pulse_stretcher #(
        .WIDTH(2), .SAMPLE_CNT_MAX(S), .HOLD_CNT_MAX(H), .GAP_CNT_MAX(G), .RETRIGGER(1)
    ) dut_rt (
        .clk(clk), .rst(rst), .pulse(pulse), .stretched(str_rt), .busy(busy_rt)
    );

    led_pulse_stretcher #(
        .WIDTH(2), .SAMPLE_CNT_MAX(S), .HOLD_CNT_MAX(H), .GAP_CNT_MAX(G), .RETRIGGER(0)
    ) dut_q (
        .clk(clk), .rst(rst), .pulse(pulse), .stretched(str_q), .busy(busy_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] out_s(input int k);
        return (k == 0) ? str_rt : str_q;
    endfunction

    function automatic logic [1:0] out_b(input int k);
        return (k == 0) ? busy_rt : busy_q;
    endfunction

    // Model: each channel tracks how many ticks of high time and of low gap remain.
    task automatic model_step();
        bit tk;
        bit p;
        tk = (m_tcnt == S - 1);
        if (rst) m_tcnt = 0;
        else     m_tcnt = tk ? 0 : m_tcnt + 1;
        for (int k = 0; k < 2; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                p = pulse[ch];
                if (rst) begin
                    hold_left[k][ch] = 0;
                    gap_left[k][ch]  = 0;
                    queued[k][ch]    = 1'b0;
                end else if (hold_left[k][ch] > 0) begin
                    if (p && k == 0) begin
                        hold_left[k][ch] = H;
                    end else begin
                        if (p) queued[k][ch] = 1'b1;
                        if (tk) begin
                            hold_left[k][ch]--;
                            if (hold_left[k][ch] == 0) gap_left[k][ch] = G;
                        end
                    end
                end else if (gap_left[k][ch] > 0) begin
                    if (p) queued[k][ch] = 1'b1;
                    if (tk) begin
                        gap_left[k][ch]--;
                        if (gap_left[k][ch] == 0 && queued[k][ch]) begin
                            hold_left[k][ch] = H;
                            queued[k][ch]    = 1'b0;
                        end
                    end
                end else if (p) begin
                    hold_left[k][ch] = H;
                    queued[k][ch]    = 1'b0;
                end
                exp_s[k][ch] = (hold_left[k][ch] > 0);
                exp_b[k][ch] = (hold_left[k][ch] > 0) || (gap_left[k][ch] > 0);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("tick", 32'(dut_rt.tick), 32'(m_tcnt == S - 1));
        for (int k = 0; k < 2; k++) begin
            check($sformatf("stretched_k%0d", k), 32'(out_s(k)), 32'(exp_s[k]));
            check($sformatf("busy_k%0d", k), 32'(out_b(k)), 32'(exp_b[k]));
        end
        if (rec_n < REC_MAX) begin
            for (int k = 0; k < 2; k++) begin
                rec_s[k][rec_n] = out_s(k);
                rec_b[k][rec_n] = out_b(k);
            end
            rec_n++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic align();
        for (int i = 0; i < S && m_tcnt != 0; i++) cycle();
    endtask

    function automatic int run_len(input int k, input int ch, input int from);
        int n;
        n = 0;
        for (int i = from; i < rec_n; i++) begin
            if (rec_s[k][i][ch] !== 1'b1) break;
            n++;
        end
        return n;
    endfunction

    function automatic int first_idx(input int k, input int ch, input bit use_busy,
                                     input logic val, input int from);
        for (int i = from; i < rec_n; i++) begin
            if ((use_busy ? rec_b[k][i][ch] : rec_s[k][i][ch]) === val) return i;
        end
        return -1;
    endfunction

    function automatic int count_rises(input int k, input int ch);
        int   n;
        logic prev;
        n    = 0;
        prev = 1'b0;
        for (int i = 0; i < rec_n; i++) begin
            if (rec_s[k][i][ch] === 1'b1 && prev !== 1'b1) n++;
            prev = rec_s[k][i][ch];
        end
        return n;
    endfunction

    function automatic int count_high(input int k, input int ch);
        int n;
        n = 0;
        for (int i = 0; i < rec_n; i++) if (rec_s[k][i][ch] !== 1'b0) n++;
        return n;
    endfunction

    initial begin
        int gap_len;
        int rise2;
        int fall1;
        int len;
        int bcnt [2];

        // Reset with both strobes asserted
        rst   = 1'b1;
        pulse = 2'b11;
        for (int c = 0; c < 3; c++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("s1_str_k%0d", k), 32'(out_s(k)), 32'd0);
                check($sformatf("s1_busy_k%0d", k), 32'(out_b(k)), 32'd0);
            end
        end
        check("s1_tick_cnt", 32'(dut_rt.tick_cnt), 32'd0);

        // Single event in the first post-reset cycle (tick_cnt == 0)
        rst   = 1'b0;
        pulse = 2'b01;
        rec_n = 0;
        cycle();
        pulse = 2'b00;
        run(29);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("s2_rise_k%0d", k), 32'(rec_s[k][0][0]), 32'd1);
            check($sformatf("s2_len_k%0d", k), 32'(run_len(k, 0, 0)), 32'd11);
            check($sformatf("s2_busy_tail_k%0d", k), 32'(first_idx(k, 0, 1'b1, 1'b0, 0) - 11), 32'd8);
            check($sformatf("s2_ch1_quiet_k%0d", k), 32'(count_high(k, 1)), 32'd0);
        end
        run(10);

        // Retrigger: second strobe 6 cycles after the first
        align();
        rec_n = 0;
        pulse = 2'b01;
        cycle();
        pulse = 2'b00;
        run(5);
        pulse = 2'b01;
        cycle();
        pulse = 2'b00;
        run(30);
        check("s3_len", 32'(run_len(0, 0, 0)), 32'd15);
        check("s3_runs", 32'(count_rises(0, 0)), 32'd1);
        run(20);

        // Queued event: three strobes inside one hold on the queueing instance
        align();
        rec_n = 0;
        for (int j = 0; j < 4; j++) begin
            pulse = 2'b01;
            cycle();
            pulse = 2'b00;
            cycle();
        end
        run(50);
        fall1 = first_idx(1, 0, 1'b0, 1'b0, 0);
        rise2 = first_idx(1, 0, 1'b0, 1'b1, fall1);
        gap_len = rise2 - fall1;
        check("s4_first_len", 32'(run_len(1, 0, 0)), 32'd11);
        check("s4_runs", 32'(count_rises(1, 0)), 32'd2);
        check("s4_gap_in_range", 32'(gap_len >= 5 && gap_len <= 8), 32'd1);
        len = run_len(1, 0, rise2);
        check("s4_second_len_in_range", 32'(len >= 9 && len <= 12), 32'd1);
        check("s4_idle", 32'(rec_b[1][rec_n-1][0]), 32'd0);
        run(10);

        // Channel independence: ch1 strobed 5 cycles after ch0
        align();
        rec_n = 0;
        pulse = 2'b01;
        cycle();
        pulse = 2'b00;
        run(4);
        pulse = 2'b10;
        cycle();
        pulse = 2'b00;
        run(30);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("s5_ch0_len_k%0d", k), 32'(run_len(k, 0, 0)), 32'd11);
            check($sformatf("s5_ch1_rise_k%0d", k), 32'(first_idx(k, 1, 1'b0, 1'b1, 0)), 32'd5);
            len = run_len(k, 1, 5);
            check($sformatf("s5_ch1_len_k%0d", k), 32'(len >= 9 && len <= 12), 32'd1);
            check($sformatf("s5_ch0_runs_k%0d", k), 32'(count_rises(k, 0)), 32'd1);
            check($sformatf("s5_ch1_runs_k%0d", k), 32'(count_rises(k, 1)), 32'd1);
        end
        run(10);

        // Reset four cycles into a hold that has a queued event
        align();
        pulse = 2'b01;
        cycle();
        pulse = 2'b00;
        cycle();
        pulse = 2'b01;
        cycle();
        pulse = 2'b00;
        cycle();
        rst   = 1'b1;
        rec_n = 0;
        cycle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("s6_drop_k%0d", k), 32'(rec_s[k][0][0]), 32'd0);
            check($sformatf("s6_busy_drop_k%0d", k), 32'(rec_b[k][0][0]), 32'd0);
        end
        rst = 1'b0;
        run(40);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("s6_no_rehold_k%0d", k), 32'(count_high(k, 0)), 32'd0);
        end

        // Random strobes, bursts and occasional resets
        bcnt[0] = 0;
        bcnt[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int ch = 0; ch < 2; ch++) begin
                if (bcnt[ch] > 0) begin
                    pulse[ch] = 1'b1;
                    bcnt[ch]--;
                end else if ($urandom_range(0, 199) == 0) begin
                    bcnt[ch]  = $urandom_range(2, 20);
                    pulse[ch] = 1'b1;
                end else begin
                    pulse[ch] = ($urandom_range(0, 15) == 0);
                end
            end
            cycle();
        end
        rst   = 1'b0;
        pulse = 2'b00;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
